// File: rtl/player_pkg.sv
// Shared types and keycode constants for the player-ship controller.
// Holds the life-cycle state encoding and the HID keycodes the ship reacts to.
package player_pkg;

   typedef enum logic [1:0] {
      ALIVE   = 2'd0,
      EXPLODE = 2'd1,
      INVULN  = 2'd2,
      DEAD    = 2'd3
   } player_state_t;

   localparam logic [7:0] KEY_A     = 8'h04;
   localparam logic [7:0] KEY_D     = 8'h07;
   localparam logic [7:0] KEY_LEFT  = 8'h50;
   localparam logic [7:0] KEY_RIGHT = 8'h4F;
   localparam logic [7:0] KEY_SPACE = 8'h2C;

endpackage

// File: rtl/player_ship_ctrl_if.sv
// Bundle between the ship controller and its neighbours (keyboard, collision,
// bullet unit, renderer). master drives keys/hit/fire_ack; slave is the ship.
interface player_ship_ctrl_if #(
   parameter int COORD_W  = 10,
   parameter int NUM_KEYS = 4
);
   logic [NUM_KEYS*8-1:0] keycodes;
   logic                  hit;
   logic                  fire_ack;
   logic [COORD_W-1:0]    player_x;
   logic [COORD_W-1:0]    player_half_w;
   logic                  fire_req;
   logic [2:0]            lives;
   logic                  visible;
   logic                  exploding;
   logic                  game_over;

   modport master (
      output keycodes, hit, fire_ack,
      input  player_x, player_half_w, fire_req,
      input  lives, visible, exploding, game_over
   );

   modport slave (
      input  keycodes, hit, fire_ack,
      output player_x, player_half_w, fire_req,
      output lives, visible, exploding, game_over
   );
endinterface

// File: rtl/player_ship_ctrl_key_scan.sv
// Combinational keycode scanner: left/right/fire are high when any slot
// holds a matching HID code. Ports: keycodes in, left/right/fire out.
module key_scan
   import player_pkg::*;
#(
   parameter int NUM_KEYS = 4
) (
   input  logic [NUM_KEYS*8-1:0] keycodes,
   output logic                  left,
   output logic                  right,
   output logic                  fire
);

   always_comb begin
      logic [7:0] slot;
      left  = 1'b0;
      right = 1'b0;
      fire  = 1'b0;
      slot  = 8'h00;
      for (int k = 0; k < NUM_KEYS; k++) begin
         slot  = keycodes[8*k +: 8];
         left  = left  | (slot == KEY_A) | (slot == KEY_LEFT);
         right = right | (slot == KEY_D) | (slot == KEY_RIGHT);
         fire  = fire  | (slot == KEY_SPACE);
      end
   end

endmodule

// File: rtl/player_ship_ctrl.sv
// Player ship: per-frame motion with wall clamp, rate-limited shot req/ack,
// and the lives FSM. Ports: frame_clk, Reset (async, high), bus (slave).
module player_ship_ctrl
   import player_pkg::*;
#(
   parameter int COORD_W        = 10,
   parameter int NUM_KEYS       = 4,
   parameter int X_MIN          = 0,
   parameter int X_MAX          = 639,
   parameter int X_START        = 320,
   parameter int STEP           = 2,
   parameter int HALF_W         = 13,
   parameter int FIRE_COOLDOWN  = 20,
   parameter int LIVES_INIT     = 3,
   parameter int EXPLODE_FRAMES = 30,
   parameter int INVULN_FRAMES  = 90
) (
   input logic               frame_clk,
   input logic               Reset,
   player_ship_ctrl_if.slave bus
);

   localparam int CD_W = (FIRE_COOLDOWN > 0) ?
      $clog2(FIRE_COOLDOWN + 1) : 1;
   localparam int PH_MAX = (EXPLODE_FRAMES > INVULN_FRAMES) ?
      EXPLODE_FRAMES : INVULN_FRAMES;
   localparam int PH_W = $clog2(PH_MAX + 1);

   // Clamp arithmetic is one bit wider so edges never wrap.
   localparam logic [COORD_W:0] X_LO   = (COORD_W+1)'(X_MIN + HALF_W);
   localparam logic [COORD_W:0] X_HI   = (COORD_W+1)'(X_MAX - HALF_W);
   localparam logic [COORD_W:0] STEP_W = (COORD_W+1)'(STEP);

   localparam logic [COORD_W-1:0] X_RST   = COORD_W'(X_START);
   localparam logic [CD_W-1:0]    CD_LOAD = CD_W'(FIRE_COOLDOWN);
   localparam logic [PH_W-1:0]    EXP_LD  = PH_W'(EXPLODE_FRAMES - 1);
   localparam logic [PH_W-1:0]    INV_LD  = PH_W'(INVULN_FRAMES - 1);
   localparam logic [2:0]         LIV_RST = 3'(LIVES_INIT);

   logic key_left, key_right, key_fire;

   key_scan #(.NUM_KEYS(NUM_KEYS)) u_key_scan (
      .keycodes (bus.keycodes),
      .left     (key_left),
      .right    (key_right),
      .fire     (key_fire)
   );

   player_state_t      state_q, state_d;
   logic [COORD_W-1:0] x_q, x_d;
   logic [2:0]         lives_q, lives_d;
   logic               fire_req_q, fire_req_d;
   logic [CD_W-1:0]    cd_q, cd_d;
   logic [PH_W-1:0]    phase_q, phase_d;
   logic [2:0]         frame_cnt_q, frame_cnt_d;
   logic               fire_prev_q, fire_prev_d;
   logic               visible_q, visible_d;
   logic               exploding_q, exploding_d;
   logic               game_over_q, game_over_d;

   logic [COORD_W-1:0] x_move;
   logic [COORD_W:0]   x_ext, x_sum;
   logic               shot_ok;

   always_comb begin
      x_ext  = {1'b0, x_q};
      x_sum  = x_ext + STEP_W;
      x_move = x_q;
      if (key_left && !key_right) begin
         if (x_ext < X_LO + STEP_W)
            x_move = COORD_W'(X_LO);
         else
            x_move = COORD_W'(x_ext - STEP_W);
      end else if (key_right && !key_left) begin
         if (x_sum > X_HI)
            x_move = COORD_W'(X_HI);
         else
            x_move = COORD_W'(x_sum);
      end
   end

   assign shot_ok = key_fire && !fire_prev_q &&
                    (cd_q == '0) && !fire_req_q;

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      lives_d     = lives_q;
      fire_req_d  = fire_req_q;
      phase_d     = phase_q;
      frame_cnt_d = frame_cnt_q + 3'd1;
      fire_prev_d = key_fire;
      cd_d        = (cd_q != '0) ? cd_q - 1'b1 : cd_q;

      if (fire_req_q && bus.fire_ack)
         fire_req_d = 1'b0;

      unique case (state_q)
         ALIVE: begin
            if (bus.hit) begin
               // Hit beats a same-frame shot and kills a pending one.
               state_d    = EXPLODE;
               lives_d    = lives_q - 3'd1;
               phase_d    = EXP_LD;
               fire_req_d = 1'b0;
            end else begin
               x_d = x_move;
               if (shot_ok) begin
                  fire_req_d = 1'b1;
                  cd_d       = CD_LOAD;
               end
            end
         end
         INVULN: begin
            x_d = x_move;
            if (shot_ok) begin
               fire_req_d = 1'b1;
               cd_d       = CD_LOAD;
            end
            if (phase_q == '0)
               state_d = ALIVE;
            else
               phase_d = phase_q - 1'b1;
         end
         EXPLODE: begin
            fire_req_d = 1'b0;
            if (phase_q == '0) begin
               if (lives_q == 3'd0) begin
                  state_d = DEAD;
               end else begin
                  state_d = INVULN;
                  x_d     = X_RST;
                  phase_d = INV_LD;
               end
            end else begin
               phase_d = phase_q - 1'b1;
            end
         end
         DEAD: begin
            fire_req_d = 1'b0;
         end
      endcase

      visible_d   = (state_d == ALIVE) ||
                    ((state_d == INVULN) && frame_cnt_d[2]);
      exploding_d = (state_d == EXPLODE);
      game_over_d = (state_d == DEAD);
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= ALIVE;
         x_q         <= X_RST;
         lives_q     <= LIV_RST;
         fire_req_q  <= 1'b0;
         cd_q        <= '0;
         phase_q     <= '0;
         frame_cnt_q <= 3'd0;
         fire_prev_q <= 1'b0;
         visible_q   <= 1'b1;
         exploding_q <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         lives_q     <= lives_d;
         fire_req_q  <= fire_req_d;
         cd_q        <= cd_d;
         phase_q     <= phase_d;
         frame_cnt_q <= frame_cnt_d;
         fire_prev_q <= fire_prev_d;
         visible_q   <= visible_d;
         exploding_q <= exploding_d;
         game_over_q <= game_over_d;
      end
   end

   assign bus.player_x      = x_q;
   assign bus.player_half_w = COORD_W'(HALF_W);
   assign bus.fire_req      = fire_req_q;
   assign bus.lives         = lives_q;
   assign bus.visible       = visible_q;
   assign bus.exploding     = exploding_q;
   assign bus.game_over     = game_over_q;

endmodule

// File: tb/tb_player_ship_ctrl.sv
// Directed bench for player_ship_ctrl: motion/clamp, key decode, fire
// edge + cooldown, lives FSM, async reset.
module tb_player_ship_ctrl;

   logic frame_clk = 1'b0;
   logic Reset     = 1'b1;

   int n_checks = 0;
   int n_errors = 0;

   player_ship_ctrl_if #(.COORD_W(10), .NUM_KEYS(4)) bus_if ();

   player_ship_ctrl dut (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .bus       (bus_if.slave)
   );

   always #5 frame_clk = ~frame_clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge frame_clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_x"},   int'(bus_if.player_x), 320);
      check({tag, "_liv"}, int'(bus_if.lives), 3);
      check({tag, "_req"}, int'(bus_if.fire_req), 0);
      check({tag, "_vis"}, int'(bus_if.visible), 1);
      check({tag, "_exp"}, int'(bus_if.exploding), 0);
      check({tag, "_go"},  int'(bus_if.game_over), 0);
   endtask

   initial begin
      int exp_x;
      int nreq;
      int age;
      int prev;
      int last_rise;
      int min_gap;
      int seen0;
      int seen1;
      int x_hold;

      bus_if.keycodes = '0;
      bus_if.hit      = 1'b0;
      bus_if.fire_ack = 1'b0;

      step();
      step();
      check_reset_vals("rst");
      check("half_w", int'(bus_if.player_half_w), 13);
      Reset = 1'b0;

      // Left to the wall, one frame at a time.
      exp_x = 320;
      bus_if.keycodes = 32'h0000_0004;
      for (int i = 0; i < 200; i++) begin
         step();
         exp_x = (exp_x - 2 < 13) ? 13 : exp_x - 2;
         check("left_walk", int'(bus_if.player_x), exp_x);
      end
      bus_if.keycodes = 32'h0000_0007;
      step();
      check("right_off_wall", int'(bus_if.player_x), 15);

      // Both directions cancel; slot 3 decodes alone.
      bus_if.keycodes = 32'h0704_0000;
      step();
      step();
      check("both_keys", int'(bus_if.player_x), 15);
      bus_if.keycodes = 32'h4F00_0000;
      step();
      check("slot3_right", int'(bus_if.player_x), 17);

      // Right wall at 639-13 = 626.
      for (int i = 0; i < 320; i++) step();
      check("right_wall", int'(bus_if.player_x), 626);
      step();
      check("right_hold", int'(bus_if.player_x), 626);
      bus_if.keycodes = 32'h0000_0050;
      step();
      check("left_off_wall", int'(bus_if.player_x), 624);

      // Space held: one request, acked two frames later.
      bus_if.keycodes = 32'h0000_002C;
      nreq = 0;
      age  = 0;
      prev = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (i == 0) check("fire_lat", int'(bus_if.fire_req), 1);
         if (bus_if.fire_req) begin
            age++;
            bus_if.fire_ack = (age == 2);
         end else begin
            age = 0;
            bus_if.fire_ack = 1'b0;
         end
         if (bus_if.fire_req && prev == 0) nreq++;
         prev = int'(bus_if.fire_req);
      end
      check("held_one_req", nreq, 1);
      check("held_x", int'(bus_if.player_x), 624);

      bus_if.keycodes = '0;
      bus_if.fire_ack = 1'b1;
      step();
      check("ack_idle", int'(bus_if.fire_req), 0);

      // Tap every 5 frames: accepted at 0,25,50,75.
      nreq      = 0;
      prev      = 0;
      last_rise = -1000;
      min_gap   = 1000;
      for (int i = 0; i < 100; i++) begin
         bus_if.keycodes = (i % 5 == 0) ? 32'h0000_002C : 32'h0;
         step();
         if (bus_if.fire_req && prev == 0) begin
            nreq++;
            if (i - last_rise < min_gap) min_gap = i - last_rise;
            last_rise = i;
         end
         prev = int'(bus_if.fire_req);
      end
      check("tap_count", nreq, 4);
      check("tap_gap", min_gap, 25);

      bus_if.keycodes = '0;
      bus_if.fire_ack = 1'b0;
      step();
      step();
      step();

      // Hit with a pending request.
      bus_if.keycodes = 32'h0000_002C;
      step();
      check("pend_req", int'(bus_if.fire_req), 1);
      bus_if.keycodes = '0;
      bus_if.hit = 1'b1;
      step();
      bus_if.hit = 1'b0;
      check("hit_req", int'(bus_if.fire_req), 0);
      check("hit_exp", int'(bus_if.exploding), 1);
      check("hit_liv", int'(bus_if.lives), 2);
      check("hit_vis", int'(bus_if.visible), 0);
      for (int i = 0; i < 29; i++) step();
      check("exp_30th", int'(bus_if.exploding), 1);
      step();
      check("exp_end", int'(bus_if.exploding), 0);
      check("respawn_x", int'(bus_if.player_x), 320);

      seen0 = 0;
      seen1 = 0;
      for (int i = 0; i < 16; i++) begin
         step();
         if (bus_if.visible) seen1 = 1;
         else seen0 = 1;
      end
      check("blink", seen0 + seen1, 2);

      bus_if.hit = 1'b1;
      step();
      bus_if.hit = 1'b0;
      check("inv_hit_liv", int'(bus_if.lives), 2);
      check("inv_hit_exp", int'(bus_if.exploding), 0);

      for (int i = 0; i < 80; i++) step();
      check("alive_vis", int'(bus_if.visible), 1);

      // Second and third hits.
      bus_if.hit = 1'b1;
      step();
      bus_if.hit = 1'b0;
      check("hit2_liv", int'(bus_if.lives), 1);
      for (int i = 0; i < 30; i++) step();
      check("hit2_inv", int'(bus_if.exploding), 0);
      for (int i = 0; i < 100; i++) step();
      bus_if.hit = 1'b1;
      step();
      bus_if.hit = 1'b0;
      check("hit3_liv", int'(bus_if.lives), 0);
      check("hit3_exp", int'(bus_if.exploding), 1);
      for (int i = 0; i < 29; i++) step();
      check("hit3_go_early", int'(bus_if.game_over), 0);
      step();
      check("dead_go", int'(bus_if.game_over), 1);
      check("dead_vis", int'(bus_if.visible), 0);
      check("dead_exp", int'(bus_if.exploding), 0);

      x_hold = int'(bus_if.player_x);
      bus_if.keycodes = 32'h0000_2C04;
      bus_if.hit = 1'b1;
      for (int i = 0; i < 5; i++) step();
      bus_if.hit = 1'b0;
      bus_if.keycodes = '0;
      check("dead_x", int'(bus_if.player_x), x_hold);
      check("dead_req", int'(bus_if.fire_req), 0);
      check("dead_liv", int'(bus_if.lives), 0);
      check("dead_hold", int'(bus_if.game_over), 1);

      // Async reset mid-explosion.
      #1;
      Reset = 1'b1;
      #1;
      check_reset_vals("rst_dead");
      Reset = 1'b0;
      bus_if.keycodes = 32'h0000_0004;
      step();
      step();
      step();
      check("move_after_rst", int'(bus_if.player_x), 314);
      bus_if.keycodes = '0;
      bus_if.hit = 1'b1;
      step();
      bus_if.hit = 1'b0;
      step();
      step();
      check("pre_rst_exp", int'(bus_if.exploding), 1);
      #1;
      Reset = 1'b1;
      #1;
      check_reset_vals("rst_exp");
      Reset = 1'b0;

      // Async reset mid-handshake.
      bus_if.keycodes = 32'h0000_002C;
      step();
      check("hs_req", int'(bus_if.fire_req), 1);
      #1;
      Reset = 1'b1;
      #1;
      check_reset_vals("rst_hs");
      Reset = 1'b0;
      bus_if.keycodes = '0;
      step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
